// File: rtl/load_mode_sel.sv
// Tape-loader mode selector: debounced F11 toggle cycles the load mode, deferred until the
// reader is idle, then a FIFO clear pulse. Optional direct select under LOAD_MODE_DIRECT_SEL_EN.
module load_mode_sel #(
    parameter int          NUM_MODES     = 4,
    parameter int          SYNC_STAGES   = 2,
    parameter int          DEBOUNCE_CYC  = 16,
    parameter int          CLR_PULSE_LEN = 4,
    parameter logic [15:0] TURBO_MASK    = 16'h000A,
    parameter int          RESET_MODE    = 0,
    localparam int         MODE_W        = $clog2(NUM_MODES)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_load_mode_tgl,
    input  logic              i_tape_busy,
    input  logic              i_sel_valid,
    input  logic [MODE_W-1:0] i_sel_id,
    output logic              o_clear_fifo,
    output logic              o_load_turbo,
    output logic [MODE_W-1:0] o_load_mode_id,
    output logic              o_busy
);

    localparam int CNT_MAX = (DEBOUNCE_CYC > CLR_PULSE_LEN) ? DEBOUNCE_CYC : CLR_PULSE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, WAIT_IDLE, APPLY, CLEAR} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tgl_s_d1;
    logic [CNT_W-1:0]       cnt;
    logic [MODE_W-1:0]      target;
    logic                   tgl_s;
    logic                   rise;
    logic                   sel_ok;

    assign tgl_s  = sync_q[SYNC_STAGES-1];
    assign rise   = tgl_s & ~tgl_s_d1;
    assign o_busy = (state != IDLE);

`ifdef LOAD_MODE_DIRECT_SEL_EN
    assign sel_ok = i_sel_valid && (32'(i_sel_id) < NUM_MODES) && (i_sel_id != o_load_mode_id);
`else
    assign sel_ok = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q         <= '0;
            tgl_s_d1       <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            target         <= MODE_W'(RESET_MODE);
            o_load_mode_id <= MODE_W'(RESET_MODE);
            o_load_turbo   <= TURBO_MASK[RESET_MODE];
            o_clear_fifo   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], i_load_mode_tgl};
            tgl_s_d1 <= tgl_s;
            case (state)
                IDLE: begin
                    o_clear_fifo <= 1'b0;
                    // Direct select has priority; a same-clock rise is dropped.
                    if (sel_ok) begin
                        target <= i_sel_id;
                        state  <= WAIT_IDLE;
                    end else if (rise) begin
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!tgl_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        target <= (o_load_mode_id == MODE_W'(NUM_MODES - 1)) ? '0
                                  : o_load_mode_id + MODE_W'(1);
                        state  <= WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (!i_tape_busy) state <= APPLY;
                end
                APPLY: begin
                    o_load_mode_id <= target;
                    o_load_turbo   <= TURBO_MASK[target];
                    cnt            <= '0;
                    state          <= CLEAR;
                end
                CLEAR: begin
                    // Pulse starts the clock after the mode update and lasts CLR_PULSE_LEN clocks.
                    if (cnt == CNT_W'(CLR_PULSE_LEN)) begin
                        o_clear_fifo <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        o_clear_fifo <= 1'b1;
                        cnt          <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_mode_sel.sv
// Directed bench for load_mode_sel (NUM_MODES=4, DEBOUNCE_CYC=8, CLR_PULSE_LEN=4, mask 0xA).
module tb_load_mode_sel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgl = 1'b0;
    logic       tape_busy = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       clr;
    logic       turbo;
    logic [1:0] mode_id;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int clr_hi = 0;
    int clr_pulses = 0;
    logic clr_prev = 1'b0;

    always #5 clk = ~clk;

    load_mode_sel #(
        .NUM_MODES(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(8), .CLR_PULSE_LEN(4),
        .TURBO_MASK(16'h000A), .RESET_MODE(0)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_load_mode_tgl(tgl), .i_tape_busy(tape_busy),
        .i_sel_valid(sel_valid), .i_sel_id(sel_id), .o_clear_fifo(clr),
        .o_load_turbo(turbo), .o_load_mode_id(mode_id), .o_busy(busy)
    );

    always @(negedge clk) begin
        if (clr) clr_hi = clr_hi + 1;
        if (clr && !clr_prev) clr_pulses = clr_pulses + 1;
        clr_prev = clr;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_id); end
        checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL reset_turbo got %b want 0", turbo); end
        checks++; if (clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", clr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    // Held 20 clocks: mode updates on the 13th edge, clear high on edges 14..17.
    task automatic test_single_press;
        int p0, h0;
        p0 = clr_pulses; h0 = clr_hi;
        tgl = 1'b1;
        step(12);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL latency_early got %0d want 0", mode_id); end
        step(1);
        checks++; if (mode_id !== 2'd1) begin errors++; $display("FAIL latency_mode got %0d want 1", mode_id); end
        checks++; if (turbo !== 1'b1) begin errors++; $display("FAIL press_turbo got %b want 1", turbo); end
        checks++; if (clr !== 1'b0) begin errors++; $display("FAIL clr_not_with_mode got %b want 0", clr); end
        step(1);
        checks++; if (clr !== 1'b1) begin errors++; $display("FAIL clr_first got %b want 1", clr); end
        step(6);
        tgl = 1'b0;
        step(10);
        checks++; if (clr_pulses - p0 !== 1) begin errors++; $display("FAIL press_pulses got %0d want 1", clr_pulses - p0); end
        checks++; if (clr_hi - h0 !== 4) begin errors++; $display("FAIL press_clr_len got %0d want 4", clr_hi - h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_end got %b want 0", busy); end
        checks++; if (mode_id !== 2'd1) begin errors++; $display("FAIL press_held_mode got %0d want 1", mode_id); end
    endtask

    task automatic test_four_presses;
        logic [1:0] exp_id [4];
        logic       exp_tb [4];
        int p0, h0;
        exp_id = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_tb = '{1'b1, 1'b0, 1'b1, 1'b0};
        test_reset();
        p0 = clr_pulses; h0 = clr_hi;
        for (int k = 0; k < 4; k++) begin
            tgl = 1'b1;
            step(12);
            tgl = 1'b0;
            step(20);
            checks++; if (mode_id !== exp_id[k]) begin errors++; $display("FAIL seq_mode[%0d] got %0d want %0d", k, mode_id, exp_id[k]); end
            checks++; if (turbo !== exp_tb[k]) begin errors++; $display("FAIL seq_turbo[%0d] got %b want %b", k, turbo, exp_tb[k]); end
        end
        checks++; if (clr_pulses - p0 !== 4) begin errors++; $display("FAIL seq_pulses got %0d want 4", clr_pulses - p0); end
        checks++; if (clr_hi - h0 !== 16) begin errors++; $display("FAIL seq_clr_len got %0d want 16", clr_hi - h0); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = clr_pulses;
        tgl = 1'b1;
        step(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", busy); end
        step(1);
        tgl = 1'b0;
        step(20);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL glitch_mode got %0d want 0", mode_id); end
        checks++; if (clr_pulses - p0 !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", clr_pulses - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    endtask

    task automatic test_busy_defer;
        tape_busy = 1'b1;
        tgl = 1'b1;
        step(20);
        tgl = 1'b0;
        step(80);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL defer_hold got %0d want 0", mode_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL defer_busy got %b want 1", busy); end
        tape_busy = 1'b0;
        step(1);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL defer_plus1 got %0d want 0", mode_id); end
        step(1);
        checks++; if (mode_id !== 2'd1) begin errors++; $display("FAIL defer_plus2 got %0d want 1", mode_id); end
        step(10);
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = clr_pulses;
        tape_busy = 1'b1;
        tgl = 1'b1;
        step(20);
        tgl = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy got %b want 1", busy); end
        rst_n = 1'b0;
        step(1);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL mid_reset_mode got %0d want 0", mode_id); end
        checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL mid_reset_turbo got %b want 0", turbo); end
        rst_n = 1'b1;
        tape_busy = 1'b0;
        step(20);
        checks++; if (clr_pulses - p0 !== 0) begin errors++; $display("FAIL mid_reset_pulses got %0d want 0", clr_pulses - p0); end
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL mid_reset_after got %0d want 0", mode_id); end
    endtask

`ifdef LOAD_MODE_DIRECT_SEL_EN
    task automatic test_direct_sel;
        int p0;
        p0 = clr_pulses;
        sel_id = 2'd3; sel_valid = 1'b1;
        step(1);
        sel_valid = 1'b0;
        step(12);
        checks++; if (mode_id !== 2'd3) begin errors++; $display("FAIL sel_mode got %0d want 3", mode_id); end
        checks++; if (turbo !== 1'b1) begin errors++; $display("FAIL sel_turbo got %b want 1", turbo); end
        checks++; if (clr_pulses - p0 !== 1) begin errors++; $display("FAIL sel_pulses got %0d want 1", clr_pulses - p0); end
        sel_valid = 1'b1;
        step(1);
        sel_valid = 1'b0;
        step(12);
        checks++; if (clr_pulses - p0 !== 1) begin errors++; $display("FAIL sel_same_pulses got %0d want 1", clr_pulses - p0); end
        tgl = 1'b1;
        step(2);
        sel_id = 2'd1; sel_valid = 1'b1;
        step(1);
        sel_valid = 1'b0;
        step(17);
        tgl = 1'b0;
        step(20);
        checks++; if (mode_id !== 2'd1) begin errors++; $display("FAIL sel_vs_rise_mode got %0d want 1", mode_id); end
        checks++; if (clr_pulses - p0 !== 2) begin errors++; $display("FAIL sel_vs_rise_pulses got %0d want 2", clr_pulses - p0); end
    endtask
`else
    task automatic test_sel_ignored;
        int p0;
        p0 = clr_pulses;
        sel_id = 2'd3; sel_valid = 1'b1;
        step(1);
        sel_valid = 1'b0;
        step(12);
        checks++; if (mode_id !== 2'd0) begin errors++; $display("FAIL sel_ignored_mode got %0d want 0", mode_id); end
        checks++; if (clr_pulses - p0 !== 0) begin errors++; $display("FAIL sel_ignored_pulses got %0d want 0", clr_pulses - p0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_four_presses();
        test_glitch();
        test_busy_defer();
        test_reset_mid();
`ifdef LOAD_MODE_DIRECT_SEL_EN
        test_direct_sel();
`else
        test_sel_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
